// File: rtl/cgra_sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// cgra_sram_arb_pkg : shared types and default timing constants for the
//                     CGRA SRAM bank arbiter
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cgra_sram_arb_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    RET    = 2'd1,
    WAKE   = 2'd2
  } arb_state_e;

  localparam int DEF_RET_IDLE_CYCLES = 64;
  localparam int DEF_WAKE_CYCLES     = 4;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : picks the first active request at or above ptr (wrapping)
//              and returns it as a one-hot grant plus its index
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int NumReq = 4
) (
  input  logic [NumReq-1:0]         req,
  input  logic [$clog2(NumReq)-1:0] ptr,
  output logic [NumReq-1:0]         gnt,
  output logic [$clog2(NumReq)-1:0] idx,
  output logic                      valid
);

  localparam int IDX_W = $clog2(NumReq);

  // One extra bit so the wrap also works when NumReq is not a power of two.
  logic [IDX_W:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NumReq)) begin
        cand = cand - (IDX_W+1)'(NumReq);
      end
      if (!valid && req[cand[IDX_W-1:0]]) begin
        valid                 = 1'b1;
        idx                   = cand[IDX_W-1:0];
        gnt[cand[IDX_W-1:0]]  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cgra_sram_arbiter.sv
// ---------------------------------------------------------------------------
// cgra_sram_arbiter : round-robin sharing of one CGRA SRAM bank with
//                     idle-timeout retention and a guarded wake-up delay
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cgra_sram_arbiter
  import cgra_sram_arb_pkg::*;
#(
  parameter  int NumReq        = 4,
  parameter  int NumWords      = 1024,
  parameter  int RetIdleCycles = DEF_RET_IDLE_CYCLES,
  parameter  int WakeCycles    = DEF_WAKE_CYCLES,
  localparam int AddrWidth     = (NumWords > 1) ? $clog2(NumWords) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq-1:0]           req_i,
  input  logic [NumReq-1:0]           we_i,
  input  logic [NumReq*AddrWidth-1:0] addr_i,
  input  logic [NumReq*32-1:0]        wdata_i,
  input  logic [NumReq*4-1:0]         be_i,
  output logic [NumReq-1:0]           gnt_o,
  output logic [NumReq-1:0]           rvalid_o,
  output logic [31:0]                 rdata_o,
  input  logic                        ret_en_i,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [AddrWidth-1:0]        mem_addr_o,
  output logic [31:0]                 mem_wdata_o,
  output logic [3:0]                  mem_be_o,
  output logic                        mem_set_retentive_o,
  input  logic [31:0]                 mem_rdata_i,
  output logic                        retentive_o
);

  localparam int IDX_W  = $clog2(NumReq);
  localparam int IDLE_W = $clog2(RetIdleCycles + 1);
  localparam int WAKE_W = $clog2(WakeCycles + 1);

  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(RetIdleCycles);
  localparam logic [WAKE_W-1:0] WAKE_INIT = WAKE_W'(WakeCycles - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NumReq - 1);

  arb_state_e         state, next_state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDLE_W-1:0]  idle_cnt, idle_cnt_nxt;
  logic [WAKE_W-1:0]  wake_cnt, wake_cnt_nxt;
  logic [NumReq-1:0]  rvalid_q;
  logic [NumReq-1:0]  arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic               grant_en;
  logic               granted;
  int                 sel;

  rr_arbiter #(.NumReq(NumReq)) u_rr_arbiter (
    .req   (req_i),
    .ptr   (rr_ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    next_state   = state;
    idle_cnt_nxt = idle_cnt;
    wake_cnt_nxt = wake_cnt;
    grant_en     = 1'b0;
    unique case (state)
      ACTIVE: begin
        grant_en = 1'b1;
        if (|req_i) begin
          idle_cnt_nxt = '0;
        end else if (idle_cnt != IDLE_MAX) begin
          idle_cnt_nxt = idle_cnt + 1'b1;
        end
        // A request in the timeout cycle keeps us active.
        if (ret_en_i && (idle_cnt == IDLE_MAX) && !(|req_i) && !(|rvalid_q)) begin
          next_state = RET;
        end
      end
      RET: begin
        if ((|req_i) || !ret_en_i) begin
          next_state   = WAKE;
          wake_cnt_nxt = WAKE_INIT;
        end
      end
      WAKE: begin
        if (wake_cnt == '0) begin
          next_state   = ACTIVE;
          idle_cnt_nxt = '0;
        end else begin
          wake_cnt_nxt = wake_cnt - 1'b1;
        end
      end
      default: next_state = ACTIVE;
    endcase
  end

  assign granted = grant_en && arb_valid;
  assign gnt_o   = granted ? arb_gnt : '0;
  assign sel     = int'(arb_idx);

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (granted) begin
      mem_req_o   = 1'b1;
      mem_we_o    = we_i[arb_idx];
      mem_addr_o  = addr_i[sel*AddrWidth +: AddrWidth];
      mem_wdata_o = wdata_i[sel*32 +: 32];
      mem_be_o    = be_i[sel*4 +: 4];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ACTIVE;
      rr_ptr   <= '0;
      idle_cnt <= '0;
      wake_cnt <= '0;
      rvalid_q <= '0;
    end else begin
      state    <= next_state;
      idle_cnt <= idle_cnt_nxt;
      wake_cnt <= wake_cnt_nxt;
      rvalid_q <= gnt_o;
      if (granted) begin
        rr_ptr <= (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
      end
    end
  end

  assign rvalid_o            = rvalid_q;
  assign rdata_o             = mem_rdata_i;
  assign mem_set_retentive_o = (state == RET);
  assign retentive_o         = (state == RET);

endmodule

`default_nettype wire

// File: tb/tb_cgra_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cgra_sram_arbiter : scoreboard bench for cgra_sram_arbiter with a
//                        behavioural SRAM bank model
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cgra_sram_arbiter;

  localparam int NR = 4;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]          req, we;
  logic [NR-1:0][AW-1:0]  addr;
  logic [NR-1:0][31:0]    wdata;
  logic [NR-1:0][3:0]     be;
  logic                   ret_en;
  logic [NR-1:0]          gnt, rvalid;
  logic [31:0]            rdata;
  logic                   mem_req, mem_we, mem_set_ret, retentive;
  logic [AW-1:0]          mem_addr;
  logic [31:0]            mem_wdata, mem_rdata;
  logic [3:0]             mem_be;

  cgra_sram_arbiter #(.NumReq(NR), .NumWords(1024)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .req_i               (req),
    .we_i                (we),
    .addr_i              (addr),
    .wdata_i             (wdata),
    .be_i                (be),
    .gnt_o               (gnt),
    .rvalid_o            (rvalid),
    .rdata_o             (rdata),
    .ret_en_i            (ret_en),
    .mem_req_o           (mem_req),
    .mem_we_o            (mem_we),
    .mem_addr_o          (mem_addr),
    .mem_wdata_o         (mem_wdata),
    .mem_be_o            (mem_be),
    .mem_set_retentive_o (mem_set_ret),
    .mem_rdata_i         (mem_rdata),
    .retentive_o         (retentive)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 5) return 32'hDEADBEEF;
    if (i == 7) return 32'h11223344;
    return (32'(i) * 32'h01000193) ^ 32'h5A5A0000;
  endfunction

  // Bank model: one-cycle read latency, byte-enabled writes.
  logic [31:0] bank [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] bank_tmp;
  bit          loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) bank[i] <= init_word(i);
      loaded <= 1'b1;
    end else if (mem_req) begin
      if (mem_we) begin
        bank_tmp = bank[mem_addr];
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) bank_tmp[8*b +: 8] = mem_wdata[8*b +: 8];
        bank[mem_addr] <= bank_tmp;
      end else begin
        mem_rdata <= bank[mem_addr];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  typedef struct {
    logic [NR-1:0] who;
    logic          is_rd;
    logic [31:0]   data;
    int            due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Responses are due exactly one cycle after their grant.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() != 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        check_eq("rvalid", rvalid, mon_e.who);
        if (mon_e.is_rd) check_eq("rdata", rdata, mon_e.data);
      end else if (rvalid != '0) begin
        check_eq("rvalid_unexp", rvalid, '0);
      end
    end
  end

  task automatic cycle_check(input string tag, input logic [NR-1:0] exp_gnt, input bit drop);
    exp_t e;
    @(negedge clk);
    check_eq({tag, "_gnt"}, gnt, exp_gnt);
    check_eq({tag, "_mreq"}, mem_req, |exp_gnt);
    for (int k = 0; k < NR; k++) begin
      if (exp_gnt[k]) begin
        check_eq({tag, "_maddr"}, mem_addr, addr[k]);
        check_eq({tag, "_mwe"}, mem_we, we[k]);
        e.who   = exp_gnt;
        e.is_rd = !we[k];
        e.due   = cyc + 1;
        e.data  = '0;
        if (we[k]) begin
          check_eq({tag, "_mwdata"}, mem_wdata, wdata[k]);
          check_eq({tag, "_mbe"}, mem_be, be[k]);
          for (int b = 0; b < 4; b++)
            if (be[k][b]) ref_mem[addr[k]][8*b +: 8] = wdata[k][8*b +: 8];
        end else begin
          e.data = ref_mem[addr[k]];
        end
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (drop) req = req & ~exp_gnt;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    req    = '0;
    we     = '0;
    ret_en = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rvalid", rvalid, '0);
    check_eq("rst_gnt", gnt, '0);
    check_eq("rst_mreq", mem_req, 1'b0);
    check_eq("rst_ret", retentive, 1'b0);
    check_eq("rst_setret", mem_set_ret, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    addr  = '0;
    wdata = '0;
    be    = '0;
    do_reset();

    // Single read
    req = 4'b0001; we = '0; addr[0] = 10'd5;
    cycle_check("t1", 4'b0001, 1'b1);
    cycle_check("t1_idle", 4'b0000, 1'b1);

    // All requesters held: strict rotation from index 0
    do_reset();
    for (int k = 0; k < NR; k++) addr[k] = AW'(10 + k);
    req = 4'b1111; we = '0;
    for (int i = 0; i < 8; i++) cycle_check("t2", 4'b0001 << (i % 4), 1'b0);
    req = '0;
    cycle_check("t2_idle", 4'b0000, 1'b1);

    // Partial write then read-back
    req = 4'b0010; we = 4'b0010; addr[1] = 10'd7; wdata[1] = 32'hAABBCCDD; be[1] = 4'b0011;
    cycle_check("t3_wr", 4'b0010, 1'b1);
    req = 4'b0010; we = '0;
    cycle_check("t3_rd", 4'b0010, 1'b1);
    cycle_check("t3_idle", 4'b0000, 1'b1);

    // Idle timeout into retention, then wake on request
    do_reset();
    ret_en = 1'b1;
    repeat (64) @(posedge clk);
    @(negedge clk);
    check_eq("t4_not_yet_ret", retentive, 1'b0);
    @(posedge clk);
    #1;
    check_eq("t4_ret", retentive, 1'b1);
    check_eq("t4_setret", mem_set_ret, 1'b1);
    req = 4'b0100; we = '0; addr[2] = 10'd5;
    cycle_check("t4_ret_gnt", 4'b0000, 1'b0);
    check_eq("t4_wake_setret", mem_set_ret, 1'b0);
    for (int i = 0; i < 4; i++) cycle_check("t4_wake_gnt", 4'b0000, 1'b0);
    cycle_check("t4_first", 4'b0100, 1'b1);
    cycle_check("t4_idle", 4'b0000, 1'b1);

    // Request in the timeout cycle wins over retention
    do_reset();
    ret_en = 1'b1;
    repeat (64) @(posedge clk);
    #1;
    req = 4'b0001; we = '0; addr[0] = 10'd5;
    cycle_check("t5a", 4'b0001, 1'b1);
    check_eq("t5a_noret", retentive, 1'b0);
    cycle_check("t5a_idle", 4'b0000, 1'b1);
    check_eq("t5a_noret2", retentive, 1'b0);

    // ret_en falling in retention wakes without any grant
    do_reset();
    ret_en = 1'b1;
    repeat (65) @(posedge clk);
    #1;
    check_eq("t5b_ret", retentive, 1'b1);
    ret_en = 1'b0;
    for (int i = 0; i < 5; i++) cycle_check("t5b_wake", 4'b0000, 1'b0);
    check_eq("t5b_active", retentive, 1'b0);
    req = 4'b0001; we = '0; addr[0] = 10'd7;
    cycle_check("t5b_gnt", 4'b0001, 1'b1);
    cycle_check("t5b_idle", 4'b0000, 1'b1);

    // Reset while a response is outstanding
    do_reset();
    req = 4'b0010; we = '0; addr[1] = 10'd5;
    @(negedge clk);
    check_eq("t6_gnt", gnt, 4'b0010);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req   = '0;
    #1;
    check_eq("t6_rvalid", rvalid, '0);
    check_eq("t6_gnt_rst", gnt, '0);
    check_eq("t6_ret", retentive, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < NR; k++) addr[k] = AW'(20 + k);
    req = 4'b1111; we = '0;
    for (int i = 0; i < 4; i++) cycle_check("t6_order", 4'b0001 << i, 1'b1);
    cycle_check("t6_idle", 4'b0000, 1'b1);

    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
